// File: rtl/mxu_data_skewer_if.sv
// Bus bundle between the tile feeder (master) and the MAC-array skewer (slave).
`ifndef LOG_ALLOWED_PRECISIONS
`define LOG_ALLOWED_PRECISIONS 2
`endif
interface mxu_data_skewer_if #(
  parameter int K      = 3,
  parameter int W      = 8,
  parameter int PREC_W = `LOG_ALLOWED_PRECISIONS
);
  logic [K*W-1:0]    s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [PREC_W-1:0] data_type_in;
  logic              stall;
  logic [K*W-1:0]    input_data;
  logic              mxu_enable;
  logic [PREC_W-1:0] data_type;
  logic              tile_done;
  logic              busy;

  modport slave (
    input  s_data, s_valid, s_last, data_type_in, stall,
    output s_ready, input_data, mxu_enable, data_type, tile_done, busy
  );
  modport master (
    output s_data, s_valid, s_last, data_type_in, stall,
    input  s_ready, input_data, mxu_enable, data_type, tile_done, busy
  );
endinterface

// File: rtl/mxu_data_skewer.sv
// Input feeder for the MAC array: FIFO-buffers K-lane vectors, skews lane j
// by j cycles, drains zeros after the tile's last vector, pulses tile_done.
`ifndef LOG_ALLOWED_PRECISIONS
`define LOG_ALLOWED_PRECISIONS 2
`endif

// One skew lane: N-deep shift chain, output is the deepest stage.
module mxu_skew_lane #(
  parameter int W = 8,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o
);
  logic [N-1:0][W-1:0] sr_q;

  // Advance the chain only on a shift edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
    end else if (shift_i) begin
      sr_q[0] <= din_i;
      for (int i = 1; i < N; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign dout_o = sr_q[N-1];
endmodule

module mxu_data_skewer #(
  parameter int K              = 3,
  parameter int max_data_width = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int PREC_W         = `LOG_ALLOWED_PRECISIONS
) (
  input  logic               clk,
  input  logic               reset,
  mxu_data_skewer_if.slave   bus
);
  localparam int W   = max_data_width;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int DCW = $clog2(K) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  logic [K*W:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [CW-1:0]       cnt_q;
  state_e              st_q, st_d;
  logic [DCW-1:0]      drain_q, drain_d;
  logic                en_q, done_q, done_d;
  logic [PREC_W-1:0]   dt_q;
  logic                push, pop, shift, load_dt;
  logic [K*W:0]        head;
  logic [K-1:0][W-1:0] lane_in, lane_out;

  assign bus.s_ready = (cnt_q < CW'(FIFO_DEPTH));
  assign push        = bus.s_valid & bus.s_ready;
  assign head        = mem_q[rptr_q];

  // FIFO storage; no reset needed, occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {bus.s_last, bus.s_data};
  end

  // FIFO pointers and occupancy; pop only sees entries present before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Control next-state: decides pop/shift/latch for this edge.
  always_comb begin
    st_d    = st_q;
    drain_d = drain_q;
    pop     = 1'b0;
    shift   = 1'b0;
    load_dt = 1'b0;
    done_d  = 1'b0;
    if (!bus.stall) begin
      case (st_q)
        IDLE: if (cnt_q != '0) begin
          pop = 1'b1; shift = 1'b1; load_dt = 1'b1; st_d = RUN;
        end
        RUN: begin
          shift = 1'b1;
          pop   = (cnt_q != '0);
        end
        DRAIN: begin
          shift   = 1'b1;
          drain_d = drain_q - 1'b1;
          if (drain_q == DCW'(1)) begin
            done_d = 1'b1; st_d = IDLE;
          end
        end
        default: st_d = IDLE;
      endcase
      // A tile's last vector ends the feed: drain K-1 zeros, or finish at once for K=1.
      if (pop && head[K*W]) begin
        if (K == 1) begin
          done_d = 1'b1; st_d = IDLE;
        end else begin
          st_d = DRAIN; drain_d = DCW'(K-1);
        end
      end
    end
  end

  assign lane_in = pop ? head[K*W-1:0] : '0;

  // State, drain counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q    <= IDLE;
      drain_q <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      dt_q    <= '0;
    end else begin
      st_q    <= st_d;
      drain_q <= drain_d;
      en_q    <= shift;
      done_q  <= done_d;
      if (load_dt) dt_q <= bus.data_type_in;
    end
  end

  for (genvar j = 0; j < K; j++) begin : g_lane
    mxu_skew_lane #(.W(W), .N(j+1)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .shift_i (shift),
      .din_i   (lane_in[j]),
      .dout_o  (lane_out[j])
    );
  end

  assign bus.input_data = lane_out;
  assign bus.mxu_enable = en_q;
  assign bus.tile_done  = done_q;
  assign bus.data_type  = dt_q;
  assign bus.busy       = (st_q != IDLE) || (cnt_q != '0);
endmodule

// File: tb/tb_mxu_data_skewer.sv
// Scoreboard bench for mxu_data_skewer: directed tiles, expected skewed
// vectors queued at issue time, negedge monitor pops on every mxu_enable.
module tb_mxu_data_skewer;
  localparam int K  = 3;
  localparam int W  = 8;
  localparam int DW = K*W;
  localparam int PW = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic [PW-1:0] dt;
    logic          done;
  } exp_t;

  logic clk, reset;
  int vectors = 0, miscompares = 0;
  exp_t exp_q[$];
  logic [DW-1:0] hist[$];

  mxu_data_skewer_if #(.K(K), .W(W), .PREC_W(PW)) bus ();

  mxu_data_skewer #(.K(K), .max_data_width(W), .FIFO_DEPTH(4), .PREC_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference skew: lane j shows lane j of the vector shifted in j shifts ago.
  task automatic sx(input logic [DW-1:0] v, input logic [PW-1:0] dt, input logic done);
    exp_t e;
    int n;
    hist.push_back(v);
    n = hist.size();
    e.data = '0;
    for (int j = 0; j < K; j++)
      if (n-1-j >= 0) e.data[j*W +: W] = hist[n-1-j][j*W +: W];
    e.dt = dt;
    e.done = done;
    exp_q.push_back(e);
  endtask

  task automatic drain_exp(input logic [PW-1:0] dt);
    for (int i = 1; i < K; i++) sx('0, dt, i == K-1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.s_last  = l;
  endtask

  // Monitor: every enabled cycle must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.mxu_enable === 1'b1) begin
      chk("sb_entry_avail", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("input_data", 64'(bus.input_data), 64'(e.data));
        chk("data_type", 64'(bus.data_type), 64'(e.dt));
        chk("tile_done", 64'(bus.tile_done), 64'(e.done));
      end
    end else begin
      chk("done_without_enable", 64'(bus.tile_done), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive(1'b0, '0, 1'b0);
    bus.stall = 1'b0;
    bus.data_type_in = '0;
    #12;
    chk("rst_input_data", 64'(bus.input_data), 64'd0);
    chk("rst_enable", 64'(bus.mxu_enable), 64'd0);
    chk("rst_data_type", 64'(bus.data_type), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd1);
    reset = 1'b1;
    tick();

    // Tile 1: two back-to-back vectors, hand-computed lane outputs.
    bus.data_type_in = 2'd3;
    sx(24'h030201, 3, 0); sx(24'h060504, 3, 0); drain_exp(3);
    drive(1'b1, 24'h030201, 1'b0); tick();            // e0
    drive(1'b1, 24'h060504, 1'b1); tick();            // e1
    drive(1'b0, '0, 1'b0);
    chk("t1_e1_data", 64'(bus.input_data), 64'h000001);
    tick();                                           // e2
    chk("t1_e2_data", 64'(bus.input_data), 64'h000204);
    tick();                                           // e3
    chk("t1_e3_data", 64'(bus.input_data), 64'h030500);
    chk("t1_e3_done", 64'(bus.tile_done), 64'd0);
    tick();                                           // e4
    chk("t1_e4_done", 64'(bus.tile_done), 64'd1);
    tick();
    chk("t1_post_done", 64'(bus.tile_done), 64'd0);
    chk("t1_post_busy", 64'(bus.busy), 64'd0);
    chk("t1_post_en", 64'(bus.mxu_enable), 64'd0);

    // Backpressure: fill the buffer under stall, a 5th vector must bounce.
    bus.stall = 1'b1;
    sx(24'h0A0B0C, 3, 0); sx(24'h111213, 3, 0); sx(24'h212223, 3, 0); sx(24'h313233, 3, 0);
    drain_exp(3);
    drive(1'b1, 24'h0A0B0C, 1'b0); tick(); chk("bp_ready1", 64'(bus.s_ready), 64'd1);
    drive(1'b1, 24'h111213, 1'b0); tick(); chk("bp_ready2", 64'(bus.s_ready), 64'd1);
    drive(1'b1, 24'h212223, 1'b0); tick(); chk("bp_ready3", 64'(bus.s_ready), 64'd1);
    drive(1'b1, 24'h313233, 1'b1); tick(); chk("bp_ready4", 64'(bus.s_ready), 64'd0);
    drive(1'b1, 24'h777777, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_full_ready", 64'(bus.s_ready), 64'd0);
      chk("bp_frozen_data", 64'(bus.input_data), 64'h060000);
      chk("bp_frozen_en", 64'(bus.mxu_enable), 64'd0);
    end
    drive(1'b0, '0, 1'b0);
    bus.stall = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_done_early", 64'(bus.tile_done), 64'd0);
    tick();
    chk("bp_done", 64'(bus.tile_done), 64'd1);
    tick();
    chk("bp_idle_busy", 64'(bus.busy), 64'd0);

    // Stall for 3 cycles in the middle of the drain.
    sx(24'h0C0B0A, 3, 0); sx(24'h0F0E0D, 3, 0); drain_exp(3);
    drive(1'b1, 24'h0C0B0A, 1'b0); tick();
    drive(1'b1, 24'h0F0E0D, 1'b1); tick();
    drive(1'b0, '0, 1'b0);
    tick(); tick();                                   // e3: one drain shift done
    chk("ds_e3_done", 64'(bus.tile_done), 64'd0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ds_frozen_data", 64'(bus.input_data), 64'h0C0E00);
      chk("ds_frozen_en", 64'(bus.mxu_enable), 64'd0);
      chk("ds_frozen_done", 64'(bus.tile_done), 64'd0);
    end
    bus.stall = 1'b0;
    tick();                                           // e7
    chk("ds_done", 64'(bus.tile_done), 64'd1);
    chk("ds_last_data", 64'(bus.input_data), 64'h0F0000);
    tick();

    // Bubble: two empty cycles between V0 and V1 become zero vectors.
    sx(24'h232221, 3, 0); sx('0, 3, 0); sx('0, 3, 0); sx(24'h262524, 3, 0); drain_exp(3);
    drive(1'b1, 24'h232221, 1'b0); tick();            // e0
    drive(1'b0, '0, 1'b0);
    tick(); chk("bub_en1", 64'(bus.mxu_enable), 64'd1);
    tick(); chk("bub_en2", 64'(bus.mxu_enable), 64'd1);
    drive(1'b1, 24'h262524, 1'b1);
    tick(); chk("bub_en3", 64'(bus.mxu_enable), 64'd1);
    drive(1'b0, '0, 1'b0);
    tick(); chk("bub_en4", 64'(bus.mxu_enable), 64'd1);
    tick(); chk("bub_done_early", 64'(bus.tile_done), 64'd0);
    tick(); chk("bub_done", 64'(bus.tile_done), 64'd1);
    tick(); chk("bub_idle_en", 64'(bus.mxu_enable), 64'd0);

    // Precision latch: a mid-tile data_type_in change is ignored.
    bus.data_type_in = 2'd2;
    sx(24'h313131, 2, 0); sx(24'h323232, 2, 0); sx(24'h333333, 2, 0); drain_exp(2);
    drive(1'b1, 24'h313131, 1'b0); tick();
    drive(1'b1, 24'h323232, 1'b0); tick();
    bus.data_type_in = 2'd1;
    drive(1'b1, 24'h333333, 1'b1); tick();
    drive(1'b0, '0, 1'b0);
    tick(); tick(); tick();
    chk("pr_done", 64'(bus.tile_done), 64'd1);
    chk("pr_dt_held", 64'(bus.data_type), 64'd2);
    sx(24'h414243, 1, 0); drain_exp(1);
    drive(1'b1, 24'h414243, 1'b1); tick();
    drive(1'b0, '0, 1'b0);
    tick(); chk("pr_dt_new", 64'(bus.data_type), 64'd1);
    tick(); tick();
    chk("pr2_done", 64'(bus.tile_done), 64'd1);
    tick();

    // Async reset in RUN with three entries buffered.
    sx(24'h515253, 1, 0);
    drive(1'b1, 24'h515253, 1'b0); tick();
    drive(1'b1, 24'h616263, 1'b0); tick();
    bus.stall = 1'b1;
    drive(1'b1, 24'h717273, 1'b0); tick();
    drive(1'b1, 24'h818283, 1'b1); tick();
    drive(1'b0, '0, 1'b0);
    tick();
    chk("ar_busy_before", 64'(bus.busy), 64'd1);
    chk("ar_sb_drained", 64'(exp_q.size()), 64'd0);
    #2 reset = 1'b0;
    #1;
    chk("ar_data", 64'(bus.input_data), 64'd0);
    chk("ar_en", 64'(bus.mxu_enable), 64'd0);
    chk("ar_done", 64'(bus.tile_done), 64'd0);
    chk("ar_ready", 64'(bus.s_ready), 64'd1);
    chk("ar_dt", 64'(bus.data_type), 64'd0);
    #10 reset = 1'b1;
    hist.delete();
    bus.stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ar_post_busy", 64'(bus.busy), 64'd0);
      chk("ar_post_en", 64'(bus.mxu_enable), 64'd0);
      chk("ar_post_done", 64'(bus.tile_done), 64'd0);
    end

    chk("sb_empty_at_end", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
